motor_pwm_driver: RTL and testbench
===================================

Name: motor_pwm_driver

Overview:
- Downstream of the direction controller. Consumes the per-wheel on/off commands `left_motor` and `right_motor` and produces PWM gate drive for each H-bridge.
- Each wheel gets a duty-cycle soft-start and soft-stop ramp, which avoids current spikes and wheel slip on the balance car.
- A global `enable` input gives an immediate hard stop for fall detection and the e-stop.

Parameters:
- PWM_BITS, 10: width of the PWM counter and duty registers; PWM period = 2^PWM_BITS ticks.
- PRESCALE, 50: clk cycles per PWM tick (legal range >= 1).
- DUTY_CRUISE, 768: target duty while a motor is commanded on. Must be <= 2^PWM_BITS-1.
- RAMP_STEP, 32: duty change per ramp event (legal range >= 1).
- RAMP_PERIODS, 4: PWM periods between ramp events (legal range >= 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  global drive enable; low = hard stop
- left_motor  in  1  left wheel run command from the direction controller (synchronous to clk)
- right_motor  in  1  right wheel run command (synchronous to clk)
- left_pwm  out  1  left H-bridge PWM, registered
- right_pwm  out  1  right H-bridge PWM, registered
- left_duty  out  PWM_BITS  current left duty (status)
- right_duty  out  PWM_BITS  current right duty (status)
- ramping  out  1  high while either channel is in RAMP_UP or RAMP_DOWN

Behaviour:
- Reset:
  - Clock is clk; reset is reset_n, asynchronous assert, active-low.
  - On reset: all counters = 0, both duties = 0, left_pwm = right_pwm = 0, both channels in IDLE, ramping = 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - `tick` = prescaler at PRESCALE-1.
- PWM counter:
  - Advances on `tick` only; wraps from 2^PWM_BITS-1 to 0.
  - `period_end` = tick AND pwm_cnt at its maximum value.
- Ramp counter:
  - Counts period_end events 0..RAMP_PERIODS-1 and wraps.
  - `ramp_evt` = period_end AND ramp counter at RAMP_PERIODS-1.
  - Prescaler, PWM counter and ramp counter run freely whenever out of reset, independent of enable.
- Output compare:
  - x_pwm <= (pwm_cnt < x_duty), registered every clk. One clk latency from the counter value.
  - duty 0 gives a constant low output. Duty only changes at period boundaries, so there are no glitch pulses.
- Per-channel FSM (identical and independent for left and right):
  - Target sampling: target = DUTY_CRUISE if motor input = 1, else 0. The target is sampled only at ramp_evt. Input toggles between events that have reverted by the next event have no effect.
  - IDLE (duty = 0): at ramp_evt with target != 0, go to RAMP_UP and duty = min(RAMP_STEP, target).
  - RAMP_UP: at ramp_evt, if target = DUTY_CRUISE then duty = min(duty+RAMP_STEP, DUTY_CRUISE). On reaching DUTY_CRUISE, go to RUN. If target = 0, go to RAMP_DOWN and duty = max(duty-RAMP_STEP, 0); the direction reversal takes effect in the same event.
  - RUN: at ramp_evt with target = 0, go to RAMP_DOWN with a step applied.
  - RAMP_DOWN: at ramp_evt, duty = max(duty-RAMP_STEP, 0); at 0 go to IDLE. If target returns to DUTY_CRUISE, go to RAMP_UP with a step applied.
  - No overshoot or underflow. Saturation arithmetic is done at PWM_BITS+1 bits.
- Enable low (hard stop):
  - On the next clk edge, for both channels: duty = 0, state = IDLE, x_pwm = 0. This overrides any ramp_evt in the same cycle.
  - While enable is low, channels stay in IDLE regardless of the motor inputs.
- Enable returns high: channels resume from IDLE and ramp up at subsequent ramp_evts. Duty never jumps directly to cruise.
- ramping output: combinational OR of the two channel states (RAMP_UP or RAMP_DOWN).
- Reset asserted mid-ramp: immediate return to reset values; no output pulse completes.

Test Plan:
Bench parameters for all scenarios: PWM_BITS=4, PRESCALE=2, RAMP_STEP=4, RAMP_PERIODS=1, DUTY_CRUISE=12. One PWM period = 32 clk.
- Reset: assert reset_n=0 mid-ramp with duty=8 -> all outputs 0 on the same edge; after release, left_pwm stays 0 for the first full period.
- Soft start: enable=1, left_motor=1 from reset -> left_duty goes 4, 8, 12 at successive period_ends; ramping high from the first event until duty=12. In RUN, left_pwm is high 24 clk of every 32. right_pwm stays 0.
- Soft stop: from RUN at 12, drop left_motor -> duty 8, 4, 0 at successive events, state returns to IDLE, ramping falls after the duty-0 event.
- Reversal: left_motor drops while ramping up at duty 8 -> next event gives duty 4 (RAMP_DOWN). Re-assert it -> next event gives 8 (RAMP_UP).
- Hard stop: both channels at 12, pull enable low coincident with a ramp_evt -> both pwm=0 and both duty=0 the next clk, ramping=0. Re-enable -> ramp restarts at 4.
- Glitch filter: pulse right_motor high for 5 clk strictly between two ramp_evts -> right_duty stays 0 and right_pwm never asserts.

Source files
------------

// File: rtl/motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// motor_pwm_driver
//
// Per-wheel PWM gate drive for the two H-bridges of the balance car. Each
// wheel has its own soft-start / soft-stop duty ramp. A shared prescaler, PWM
// counter and ramp-period counter pace both channels. The global enable input
// performs an immediate hard stop.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       global drive enable; low forces both channels to IDLE, duty 0
//   left_motor   left wheel run command (synchronous to clk)
//   right_motor  right wheel run command (synchronous to clk)
//   left_pwm     left H-bridge PWM, registered
//   right_pwm    right H-bridge PWM, registered
//   left_duty    current left duty (status)
//   right_duty   current right duty (status)
//   ramping      high while either channel is in RAMP_UP or RAMP_DOWN
// -----------------------------------------------------------------------------
module motor_pwm_driver #(
    parameter int PWM_BITS     = 10,
    parameter int PRESCALE     = 50,
    parameter int DUTY_CRUISE  = 768,
    parameter int RAMP_STEP    = 32,
    parameter int RAMP_PERIODS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                left_motor,
    input  logic                right_motor,
    output logic                left_pwm,
    output logic                right_pwm,
    output logic [PWM_BITS-1:0] left_duty,
    output logic [PWM_BITS-1:0] right_duty,
    output logic                ramping
);

    // A 1-entry counter still needs one bit of storage.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    // Saturation arithmetic is one bit wider than the duty so a step never wraps.
    localparam int DW   = PWM_BITS + 1;

    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]     PS_ONE   = PS_W'(1);
    localparam logic [RC_W-1:0]     RC_LAST  = RC_W'(RAMP_PERIODS - 1);
    localparam logic [RC_W-1:0]     RC_ONE   = RC_W'(1);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};
    localparam logic [DW-1:0]       CRUISE_W = DW'(DUTY_CRUISE);
    localparam logic [DW-1:0]       STEP_W   = DW'(RAMP_STEP);
    localparam logic [PWM_BITS-1:0] CRUISE_D = CRUISE_W[PWM_BITS-1:0];

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } ch_state_t;

    // Duty + one step, clamped at cruise.
    function automatic logic [PWM_BITS-1:0] sat_up(input logic [PWM_BITS-1:0] d);
        logic [DW-1:0] sum;
        sum = {1'b0, d} + STEP_W;
        if (sum > CRUISE_W) begin
            sat_up = CRUISE_D;
        end else begin
            sat_up = sum[PWM_BITS-1:0];
        end
    endfunction

    // Duty - one step, clamped at zero.
    function automatic logic [PWM_BITS-1:0] sat_dn(input logic [PWM_BITS-1:0] d);
        logic [DW-1:0] diff;
        diff = {1'b0, d} - STEP_W;
        if ({1'b0, d} >= STEP_W) begin
            sat_dn = diff[PWM_BITS-1:0];
        end else begin
            sat_dn = DUTY_ZERO;
        end
    endfunction

    logic [PS_W-1:0]     ps_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [RC_W-1:0]     ramp_cnt_r;
    logic                tick_s;
    logic                period_end_s;
    logic                ramp_evt_s;
    logic [1:0]          motor_s;
    logic [1:0]          tgt_on_s;
    logic [1:0]          busy_s;
    logic [1:0]          pwm_r;
    ch_state_t           state_r     [2];
    ch_state_t           nxt_state_s [2];
    logic [PWM_BITS-1:0] duty_r      [2];
    logic [PWM_BITS-1:0] nxt_duty_s  [2];

    assign tick_s       = (ps_r == PS_LAST);
    assign period_end_s = tick_s && (pwm_cnt_r == CNT_MAX);
    assign ramp_evt_s   = period_end_s && (ramp_cnt_r == RC_LAST);

    // Index 0 is the left wheel, index 1 the right wheel.
    assign motor_s  = {right_motor, left_motor};
    // A zero cruise duty means the target is always zero, whatever the command.
    assign tgt_on_s = (DUTY_CRUISE != 0) ? motor_s : 2'b00;

    // Prescaler: free-running 0..PRESCALE-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_r <= {PS_W{1'b0}};
        end else if (tick_s) begin
            ps_r <= {PS_W{1'b0}};
        end else begin
            ps_r <= ps_r + PS_ONE;
        end
    end

    // PWM counter: advances once per tick, wraps naturally at its full width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
        end else if (tick_s) begin
            pwm_cnt_r <= pwm_cnt_r + CNT_ONE;
        end
    end

    // Ramp counter: counts PWM periods between ramp events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ramp_cnt_r <= {RC_W{1'b0}};
        end else if (period_end_s) begin
            if (ramp_cnt_r == RC_LAST) begin
                ramp_cnt_r <= {RC_W{1'b0}};
            end else begin
                ramp_cnt_r <= ramp_cnt_r + RC_ONE;
            end
        end
    end

    // Channel next state at a ramp event. Every state moves one step toward the
    // sampled target, so a reversal takes effect in the same event; the state
    // then follows from where the duty lands.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            nxt_state_s[ch] = state_r[ch];
            nxt_duty_s[ch]  = duty_r[ch];
            case (state_r[ch])
                ST_IDLE, ST_RAMP_UP, ST_RUN, ST_RAMP_DOWN: begin
                    if (tgt_on_s[ch]) begin
                        nxt_duty_s[ch]  = sat_up(duty_r[ch]);
                        nxt_state_s[ch] = (sat_up(duty_r[ch]) == CRUISE_D) ? ST_RUN : ST_RAMP_UP;
                    end else begin
                        nxt_duty_s[ch]  = sat_dn(duty_r[ch]);
                        nxt_state_s[ch] = (sat_dn(duty_r[ch]) == DUTY_ZERO) ? ST_IDLE : ST_RAMP_DOWN;
                    end
                end
                default: begin
                    nxt_state_s[ch] = ST_IDLE;
                    nxt_duty_s[ch]  = DUTY_ZERO;
                end
            endcase
        end
    end

    // Channel FSM and duty registers; hard stop overrides a same-cycle ramp event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= ST_IDLE;
                duty_r[ch]  <= DUTY_ZERO;
            end
        end else if (!enable) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= ST_IDLE;
                duty_r[ch]  <= DUTY_ZERO;
            end
        end else if (ramp_evt_s) begin
            for (int ch = 0; ch < 2; ch++) begin
                state_r[ch] <= nxt_state_s[ch];
                duty_r[ch]  <= nxt_duty_s[ch];
            end
        end
    end

    // Output compare. Duty only moves when the counter wraps, so no runt pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_r <= 2'b00;
        end else if (!enable) begin
            pwm_r <= 2'b00;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                pwm_r[ch] <= (pwm_cnt_r < duty_r[ch]);
            end
        end
    end

    // Per-channel ramp-in-progress decode.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            busy_s[ch] = (state_r[ch] == ST_RAMP_UP) || (state_r[ch] == ST_RAMP_DOWN);
        end
    end

    assign ramping    = |busy_s;
    assign left_pwm   = pwm_r[0];
    assign right_pwm  = pwm_r[1];
    assign left_duty  = duty_r[0];
    assign right_duty = duty_r[1];

endmodule

// File: tb/tb_motor_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_motor_pwm_driver
//
// Bench for motor_pwm_driver with a small configuration (4-bit PWM, prescale 2,
// step 4, cruise 12, ramp every period: one PWM period and one ramp event every
// 32 clk). The reference model works from elapsed clock count: the counter
// value is (n / PRESCALE) mod 16, a ramp event closes every 32nd clk, and the
// duty moves one saturated step toward the sampled target at each event.
// -----------------------------------------------------------------------------
module tb_motor_pwm_driver;

    localparam int PB      = 4;
    localparam int PS      = 2;
    localparam int CR      = 12;
    localparam int ST      = 4;
    localparam int RP      = 1;
    localparam int EVT_PER = PS * (1 << PB) * RP;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          left_motor;
    logic          right_motor;
    logic          left_pwm;
    logic          right_pwm;
    logic [PB-1:0] left_duty;
    logic [PB-1:0] right_duty;
    logic          ramping;

    int vectors = 0;
    int errors  = 0;

    // Reference model state.
    int m_n       = 0;
    int m_duty[2] = '{0, 0};
    bit m_pwm[2]  = '{1'b0, 1'b0};

    motor_pwm_driver #(
        .PWM_BITS    (PB),
        .PRESCALE    (PS),
        .DUTY_CRUISE (CR),
        .RAMP_STEP   (ST),
        .RAMP_PERIODS(RP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .left_motor (left_motor),
        .right_motor(right_motor),
        .left_pwm   (left_pwm),
        .right_pwm  (right_pwm),
        .left_duty  (left_duty),
        .right_duty (right_duty),
        .ramping    (ramping)
    );

    always #5 clk = ~clk;

    // One saturated step toward the target.
    function automatic int mstep(int d, bit on);
        int t;
        t = on ? CR : 0;
        if (d < t) return (d + ST > t) ? t : d + ST;
        if (d > t) return (d > ST) ? d - ST : 0;
        return d;
    endfunction

    function automatic bit m_busy(int d);
        return (d > 0) && (d < CR);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on every clk edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_n       <= 0;
            m_duty[0] <= 0;
            m_duty[1] <= 0;
            m_pwm[0]  <= 1'b0;
            m_pwm[1]  <= 1'b0;
        end else begin
            m_n <= m_n + 1;
            if (!enable) begin
                m_duty[0] <= 0;
                m_duty[1] <= 0;
                m_pwm[0]  <= 1'b0;
                m_pwm[1]  <= 1'b0;
            end else begin
                m_pwm[0] <= ((m_n / PS) % (1 << PB)) < m_duty[0];
                m_pwm[1] <= ((m_n / PS) % (1 << PB)) < m_duty[1];
                if (((m_n + 1) % EVT_PER) == 0) begin
                    m_duty[0] <= mstep(m_duty[0], left_motor);
                    m_duty[1] <= mstep(m_duty[1], right_motor);
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        chk("left_pwm",   32'(left_pwm),   32'(m_pwm[0]));
        chk("right_pwm",  32'(right_pwm),  32'(m_pwm[1]));
        chk("left_duty",  32'(left_duty),  m_duty[0]);
        chk("right_duty", 32'(right_duty), m_duty[1]);
        chk("ramping",    32'(ramping),    32'(m_busy(m_duty[0]) || m_busy(m_duty[1])));
    end

    // Advance to just after the next ramp-event edge.
    task automatic next_evt();
        for (int i = 0; i < EVT_PER + 4; i++) begin
            @(posedge clk);
            #2;
            if (m_n % EVT_PER == 0) return;
        end
        vectors++;
        errors++;
        $display("FAIL evt_timeout: got no ramp event expected one within %0d clk", EVT_PER + 4);
    endtask

    // Advance to the cycle during which a ramp event is pending.
    task automatic pre_evt();
        for (int i = 0; i < EVT_PER + 4; i++) begin
            @(posedge clk);
            #2;
            if (m_n % EVT_PER == EVT_PER - 1) return;
        end
        vectors++;
        errors++;
        $display("FAIL pre_evt_timeout: got no pending event expected one within %0d clk", EVT_PER + 4);
    endtask

    initial begin
        int hi;
        int rhi;
        reset_n     = 1'b0;
        enable      = 1'b0;
        left_motor  = 1'b0;
        right_motor = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        chk("reset_duty", 32'(left_duty), 32'd0);
        chk("reset_ramping", 32'(ramping), 32'd0);

        // Soft start on the left wheel.
        enable     = 1'b1;
        left_motor = 1'b1;
        next_evt();
        chk("ss_duty4", 32'(left_duty), 32'd4);
        chk("ss_ramping", 32'(ramping), 32'd1);
        next_evt();
        chk("ss_duty8", 32'(left_duty), 32'd8);
        next_evt();
        chk("ss_duty12", 32'(left_duty), 32'd12);
        chk("ss_run_ramping", 32'(ramping), 32'd0);
        hi  = 0;
        rhi = 0;
        repeat (EVT_PER) begin
            @(negedge clk);
            hi  += int'(left_pwm);
            rhi += int'(right_pwm);
        end
        chk("run_high_clk", hi, 32'd24);
        chk("run_right_high_clk", rhi, 32'd0);

        // Soft stop.
        left_motor = 1'b0;
        next_evt();
        chk("sd_duty8", 32'(left_duty), 32'd8);
        next_evt();
        chk("sd_duty4", 32'(left_duty), 32'd4);
        next_evt();
        chk("sd_duty0", 32'(left_duty), 32'd0);
        chk("sd_ramping", 32'(ramping), 32'd0);

        // Reversal mid-ramp.
        left_motor = 1'b1;
        next_evt();
        next_evt();
        chk("rev_up8", 32'(left_duty), 32'd8);
        left_motor = 1'b0;
        next_evt();
        chk("rev_down4", 32'(left_duty), 32'd4);
        left_motor = 1'b1;
        next_evt();
        chk("rev_up8b", 32'(left_duty), 32'd8);
        next_evt();

        // Hard stop coincident with a ramp event.
        right_motor = 1'b1;
        repeat (3) next_evt();
        chk("hs_left12", 32'(left_duty), 32'd12);
        chk("hs_right12", 32'(right_duty), 32'd12);
        pre_evt();
        enable = 1'b0;
        @(posedge clk);
        #2;
        chk("hs_left_duty", 32'(left_duty), 32'd0);
        chk("hs_right_duty", 32'(right_duty), 32'd0);
        chk("hs_left_pwm", 32'(left_pwm), 32'd0);
        chk("hs_right_pwm", 32'(right_pwm), 32'd0);
        chk("hs_ramping", 32'(ramping), 32'd0);
        repeat (2) next_evt();
        chk("hs_hold", 32'(left_duty), 32'd0);
        enable = 1'b1;
        next_evt();
        chk("hs_restart_l", 32'(left_duty), 32'd4);
        chk("hs_restart_r", 32'(right_duty), 32'd4);

        // Glitch filter: short pulse between events is ignored.
        left_motor  = 1'b0;
        right_motor = 1'b0;
        repeat (3) next_evt();
        repeat (10) @(posedge clk);
        #2 right_motor = 1'b1;
        rhi = 0;
        repeat (5) begin
            @(negedge clk);
            rhi += int'(right_pwm);
        end
        @(posedge clk);
        #2 right_motor = 1'b0;
        next_evt();
        chk("glitch_duty", 32'(right_duty), 32'd0);
        repeat (EVT_PER) begin
            @(negedge clk);
            rhi += int'(right_pwm);
        end
        chk("glitch_pwm_high", rhi, 32'd0);

        // Reset asserted mid-ramp.
        left_motor = 1'b1;
        next_evt();
        next_evt();
        chk("rst_pre_duty8", 32'(left_duty), 32'd8);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_left_pwm", 32'(left_pwm), 32'd0);
        chk("rst_left_duty", 32'(left_duty), 32'd0);
        chk("rst_ramping", 32'(ramping), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        hi = 0;
        repeat (EVT_PER) begin
            @(negedge clk);
            hi += int'(left_pwm);
        end
        chk("rst_first_period", hi, 32'd0);

        // Randomized commands and hard stops.
        repeat (3000) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 39) == 0) left_motor = ~left_motor;
            if ($urandom_range(0, 39) == 0) right_motor = ~right_motor;
            if (enable) enable = ($urandom_range(0, 299) != 0);
            else        enable = ($urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
